// File: rtl/m_clint_smp.sv
// Core-local interruptor for an SMP cluster: shared mtime, per-hart mtimecmp/msip, timer/soft IRQs.
// Optional mtime prescaler enabled by defining CLINT_PRESCALE_EN (ratio TICK_DIV).

module m_clint_hart (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        we_msip,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] mtime,
  output logic        msip,
  output logic [63:0] mtimecmp,
  output logic        mtip
);
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      // compare the values currently held, so a change shows on mtip one cycle later
      mtip <= (mtime >= mtimecmp);
      if (we_msip) msip <= wdata[0];
      if (we_lo)   mtimecmp[31:0]  <= wdata;
      if (we_hi)   mtimecmp[63:32] <= wdata;
    end
  end
endmodule

module m_clint_smp #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 10
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_we,
  input  logic               w_re,
  input  logic [15:0]        w_addr,
  input  logic [31:0]        w_wdata,
  output logic [31:0]        r_rdata,
  output logic               r_rvalid,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [63:0]        w_mtime
);
  logic [63:0]              mtime;
  logic [N_HARTS-1:0][63:0] mtimecmp;
  logic [11:0]              msip_idx;
  logic [10:0]              cmp_idx;
  logic                     in_msip, in_cmp, hit_lo, hit_hi, mtime_we, tick, rd_en;
  logic [31:0]              rd_mux;

  assign msip_idx = w_addr[13:2];
  assign cmp_idx  = w_addr[13:3];
  assign in_msip  = (w_addr[15:14] == 2'b00);
  assign in_cmp   = (w_addr[15:14] == 2'b01);
  assign hit_lo   = (w_addr[15:2] == 14'h2FFE);
  assign hit_hi   = (w_addr[15:2] == 14'h2FFF);
  assign mtime_we = w_we & (hit_lo | hit_hi);
  assign rd_en    = w_re & ~w_we;
  assign w_mtime  = mtime;

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    m_clint_hart u_hart (
      .CLK     (CLK),
      .RST_X   (RST_X),
      .we_msip (w_we & in_msip & (msip_idx == 12'(h))),
      .we_lo   (w_we & in_cmp & (cmp_idx == 11'(h)) & ~w_addr[2]),
      .we_hi   (w_we & in_cmp & (cmp_idx == 11'(h)) &  w_addr[2]),
      .wdata   (w_wdata),
      .mtime   (mtime),
      .msip    (w_msip[h]),
      .mtimecmp(mtimecmp[h]),
      .mtip    (w_mtip[h])
    );
  end

`ifdef CLINT_PRESCALE_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] pre_cnt;

  assign tick = (pre_cnt == CW'(TICK_DIV - 1));

  // an mtime write restarts the prescale period
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)        pre_cnt <= '0;
    else if (mtime_we) pre_cnt <= '0;
    else if (tick)     pre_cnt <= '0;
    else               pre_cnt <= pre_cnt + 1'b1;
  end
`else
  logic unused_tick_div;
  assign unused_tick_div = (TICK_DIV == 0);
  assign tick = 1'b1;
`endif

  // a write to either half owns the cycle: that tick is dropped, no carry across halves
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)      mtime <= '0;
    else if (hit_lo && w_we) mtime[31:0]  <= w_wdata;
    else if (hit_hi && w_we) mtime[63:32] <= w_wdata;
    else if (tick)   mtime <= mtime + 64'd1;
  end

  always_comb begin
    rd_mux = '0;
    if (hit_lo) rd_mux = mtime[31:0];
    if (hit_hi) rd_mux = mtime[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      if (in_msip && msip_idx == 12'(h)) rd_mux = {31'b0, w_msip[h]};
      if (in_cmp && cmp_idx == 11'(h))
        rd_mux = w_addr[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_en;
      if (rd_en) r_rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_m_clint_smp.sv
// Scoreboard bench for m_clint_smp (N_HARTS=2): random and directed register traffic vs a cycle model.
module tb_m_clint_smp;
  localparam int NH = 2;
`ifdef CLINT_PRESCALE_EN
  localparam int TD = 4;
`else
  localparam int TD = 1;
`endif

  logic          CLK = 1'b0, RST_X = 1'b0;
  logic          w_we = 1'b0, w_re = 1'b0;
  logic [15:0]   w_addr = '0;
  logic [31:0]   w_wdata = '0;
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic [NH-1:0] w_mtip, w_msip;
  logic [63:0]   w_mtime;

  m_clint_smp #(.N_HARTS(NH), .TICK_DIV(4)) dut (
    .CLK(CLK), .RST_X(RST_X), .w_we(w_we), .w_re(w_re), .w_addr(w_addr), .w_wdata(w_wdata),
    .r_rdata(r_rdata), .r_rvalid(r_rvalid), .w_mtip(w_mtip), .w_msip(w_msip), .w_mtime(w_mtime)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] d; int due; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  // reference state: register values as the spec describes them
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic          m_msip [NH];
  logic [NH-1:0] m_mtip;
  logic [31:0]   last_rd;
  int            ncyc, anchor;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_mtime = '0; m_mtip = '0; last_rd = '0; ncyc = 0; anchor = 0;
    for (int h = 0; h < NH; h++) begin m_cmp[h] = '1; m_msip[h] = 1'b0; end
  endfunction

  function automatic logic [31:0] rd_model(logic [15:0] a);
    int off, h;
    off = int'(a) & 'hFFFC;
    if (off == 'hBFF8) return m_mtime[31:0];
    if (off == 'hBFFC) return m_mtime[63:32];
    if (off < 'h4000) begin
      h = off / 4;
      return (h < NH) ? {31'b0, m_msip[h]} : 32'h0;
    end
    if (off < 'h8000) begin
      h = (off - 'h4000) / 8;
      if (h < NH) return (off % 8 != 0) ? m_cmp[h][63:32] : m_cmp[h][31:0];
    end
    return 32'h0;
  endfunction

  always @(posedge CLK) begin : model
    int off, h;
    bit wr_mt;
    if (RST_X) begin
      ncyc++;
      for (int k = 0; k < NH; k++) m_mtip[k] = (m_mtime >= m_cmp[k]);
      wr_mt = 1'b0;
      if (w_we) begin
        off = int'(w_addr) & 'hFFFC;
        if (off == 'hBFF8) begin m_mtime[31:0] = w_wdata; wr_mt = 1'b1; end
        else if (off == 'hBFFC) begin m_mtime[63:32] = w_wdata; wr_mt = 1'b1; end
        else if (off < 'h4000) begin
          h = off / 4;
          if (h < NH) m_msip[h] = w_wdata[0];
        end else if (off < 'h8000) begin
          h = (off - 'h4000) / 8;
          if (h < NH) begin
            if (off % 8 != 0) m_cmp[h][63:32] = w_wdata;
            else              m_cmp[h][31:0]  = w_wdata;
          end
        end
      end
      if (wr_mt) anchor = ncyc;
      else if ((ncyc - anchor) % TD == 0) m_mtime = m_mtime + 64'd1;
    end
  end

  always @(negedge CLK) begin : monitor
    if (!RST_X) begin
      chk("rst_mtime", w_mtime, 64'h0);
      chk("rst_mtip", w_mtip, 0);
      chk("rst_msip", w_msip, 0);
      chk("rst_rvalid", r_rvalid, 0);
      chk("rst_rdata", r_rdata, 0);
    end else begin
      chk("mtime", w_mtime, m_mtime);
      chk("mtip", w_mtip, m_mtip);
      for (int h = 0; h < NH; h++) chk("msip", w_msip[h], m_msip[h]);
      if (exp_q.size() > 0 && exp_q[0].due == ncyc) begin
        chk("rvalid_hi", r_rvalid, 1);
        chk("rdata", r_rdata, exp_q[0].d);
        last_rd = exp_q[0].d;
        void'(exp_q.pop_front());
      end else begin
        chk("rvalid_lo", r_rvalid, 0);
        chk("rdata_hold", r_rdata, last_rd);
      end
    end
  end

  // one bus cycle: inputs change shortly after the active edge and hold for one edge
  task automatic op(bit we, bit re, logic [15:0] a, logic [31:0] d);
    exp_t e;
    @(posedge CLK); #2;
    w_we = we; w_re = re; w_addr = a; w_wdata = d;
    if (re && !we) begin
      e.d = rd_model(a); e.due = ncyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(int n);
    repeat (n) op(0, 0, 16'h0, 32'h0);
  endtask

  task automatic do_reset(int n);
    RST_X = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("rst_now_mtime", w_mtime, 64'h0);
    chk("rst_now_mtip", w_mtip, 0);
    chk("rst_now_msip", w_msip, 0);
    chk("rst_now_rvalid", r_rvalid, 0);
    chk("rst_now_rdata", r_rdata, 0);
    w_we = 1'b0; w_re = 1'b0;
    repeat (n) @(posedge CLK);
    #2 RST_X = 1'b1;
  endtask

  logic [15:0] addrs [12] = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                             16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'h1234, 16'h8000};

  initial begin
    model_reset();
    repeat (3) @(posedge CLK);
    #2 RST_X = 1'b1;
    idle(5);
    chk("mtime_after_5", w_mtime, 64'(5 / TD));
    op(0, 1, 16'h4000, 0);
    idle(1);
    // hart 1 compare at 20, then move it far away
    op(1, 0, 16'h4008, 32'd20);
    op(1, 0, 16'h400C, 32'd0);
    idle(30 * TD);
    op(0, 1, 16'h4008, 0);
    op(1, 0, 16'h400C, 32'd1);
    idle(3);
    // mtime wrap
    op(1, 0, 16'hBFF8, 32'hFFFF_FFFF);
    op(1, 0, 16'hBFFC, 32'hFFFF_FFFF);
    idle(3 * TD + 2);
    op(0, 1, 16'hBFFC, 0);
    // soft interrupts and unmapped hart
    op(1, 0, 16'h0004, 32'h3);
    op(0, 1, 16'h0004, 0);
    op(1, 0, 16'h0008, 32'h1);
    op(0, 1, 16'h0008, 0);
    op(0, 1, 16'h1234, 0);
    op(0, 1, 16'h8000, 0);
    // prescale phase: write mid-period
    idle(2);
    op(1, 0, 16'hBFF8, 32'h100);
    idle(2 * TD + 3);
    // simultaneous write/read: read dropped
    op(1, 1, 16'hBFF8, 32'h55);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 11);
      if (r < 3)      op(1, 0, addrs[k], $urandom);
      else if (r < 6) op(0, 1, addrs[k], 0);
      else if (r == 6) op(1, 1, addrs[k], $urandom);
      else            idle(1);
    end
    // reset pulled low while a write is pending
    op(1, 0, 16'h4000, 32'h5);
    #1;
    do_reset(2);
    idle(4);
    op(0, 1, 16'h4000, 0);
    for (int i = 0; i < 100; i++) begin
      int k;
      k = $urandom_range(0, 11);
      op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, addrs[k], $urandom);
    end
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
